// File: rtl/seq_arb_4in_rr_burst_pkg.sv
// Shared definitions for the 4-input burst-holding round-robin arbiter:
// FSM state constants and small one-hot / index / rotate helpers.
package seq_arb_4in_rr_burst_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [0:0] state_t;

    // IDLE arbitrates among requesters; BUSY routes only the locked owner.
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/seq_arb_4in_rr_burst_arb_rr_pick4.sv
// Combinational round-robin pick: the first set request found when scanning
// upward (with wrap) from the one-hot priority position wins.
module arb_rr_pick4
    import seq_arb_4in_rr_burst_pkg::*;
(
    input  logic [3:0] reqs,
    input  logic [3:0] prio,
    output logic [3:0] grant
);

    logic [1:0] base;
    logic [1:0] idx;
    logic       found;

    assign base = onehot_to_idx(prio);

    // Scan four positions starting at the priority index and grant the first requester seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = base + k[1:0];
            if (!found && reqs[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_arb_4in_rr_burst.sv
// Four-requester round-robin arbiter that holds ownership of the downstream
// port for a whole burst, so beats from different requesters never interleave.
module seq_arb_4in_rr_burst
    import seq_arb_4in_rr_burst_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             in_val,
    output logic [3:0]             in_rdy,
    input  logic [3:0]             in_last,
    input  logic [4*p_nbits-1:0]   in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_msg,
    output logic                   out_last,
    output logic [1:0]             out_src,
    output logic [3:0]             grants
);

    state_t     state_q;
    logic [1:0] owner_q;
    logic [3:0] prio_q;

    logic [3:0] pick_grant;
    logic [3:0] sel_grants;
    logic [1:0] sel_src;
    logic       sel_val;
    logic       fire;

    arb_rr_pick4 u_pick (
        .reqs  (in_val),
        .prio  (prio_q),
        .grant (pick_grant)
    );

    // Choose who drives the downstream port: fresh winner in IDLE, locked owner in BUSY, nobody in reset.
    always_comb begin
        sel_grants = '0;
        sel_src    = '0;
        sel_val    = 1'b0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                sel_grants = pick_grant;
                sel_src    = onehot_to_idx(pick_grant);
                sel_val    = |in_val;
            end else begin
                sel_grants = idx_to_onehot(owner_q);
                sel_src    = owner_q;
                sel_val    = in_val[owner_q];
            end
        end
    end

    // Route the selected requester's payload and last flag downstream, zero while in reset.
    always_comb begin
        out_msg  = '0;
        out_last = 1'b0;
        if (!reset) begin
            out_msg  = in_msg[sel_src*p_nbits +: p_nbits];
            out_last = in_last[sel_src];
        end
    end

    assign grants  = sel_grants;
    assign out_src = sel_src;
    assign out_val = sel_val;
    assign in_rdy  = sel_grants & {4{out_rdy}};
    assign fire    = sel_val & out_rdy;

    // Lock the owner on any offered beat that does not end the burst, and advance priority only on burst completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            prio_q  <= 4'b0001;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_val) begin
                        if (fire && out_last) begin
                            prio_q <= rotl4(sel_grants);
                        end else begin
                            state_q <= ST_BUSY;
                            owner_q <= sel_src;
                        end
                    end
                end
                default: begin
                    if (fire && out_last) begin
                        state_q <= ST_IDLE;
                        prio_q  <= rotl4(sel_grants);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arb_4in_rr_burst.sv
// Self-checking bench for the burst-holding round-robin arbiter: fixed vectors,
// hand-written corner sequences, then randomized traffic against a reference model.
module tb_seq_arb_4in_rr_burst;

    logic        clk;
    logic        reset;
    logic [3:0]  in_val;
    logic [3:0]  in_rdy;
    logic [3:0]  in_last;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_msg;
    logic        out_last;
    logic [1:0]  out_src;
    logic [3:0]  grants;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] expGrants;
        logic [3:0] expInRdy;
        logic       expOutVal;
        logic [1:0] expSrc;
    } vec_t;

    vec_t vecs[9];

    // reference model state: burst lock, owner index, priority index
    bit mBusy;
    int mOwner;
    int mPrio;
    int win;
    logic [3:0] eG, eR;
    logic       eV, eLast;
    logic [1:0] eSrc;
    logic [7:0] eMsg;

    logic [3:0]  valR, lastR, accPrev;
    logic        rdyR, rstR;
    logic [31:0] msgR;
    int          waitCnt[4];
    int          burstOwner;

    seq_arb_4in_rr_burst #(.p_nbits(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_last  (in_last),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .out_last (out_last),
        .out_src  (out_src),
        .grants   (grants)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, input logic [3:0] val, input logic [3:0] last,
                                 input logic rdy);
        reset   = rst;
        in_val  = val;
        in_last = last;
        out_rdy = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // one cycle with hand-derived expectations; payload of requester i is 8'hA0+i
    task automatic runCheck(input string tag, input logic rst, input logic [3:0] val,
                            input logic [3:0] last, input logic rdy, input logic [3:0] expG,
                            input logic [3:0] expR, input logic expV, input logic [1:0] expSrc);
        applyStimulus(rst, val, last, rdy);
        @(negedge clk);
        checkOutput({tag, ".grants"}, grants, expG);
        checkOutput({tag, ".in_rdy"}, in_rdy, expR);
        checkOutput({tag, ".out_val"}, out_val, expV);
        if (expV) begin
            checkOutput({tag, ".out_src"}, out_src, expSrc);
            checkOutput({tag, ".out_msg"}, out_msg, 8'hA0 | {6'b0, expSrc});
            checkOutput({tag, ".out_last"}, out_last, last[expSrc]);
        end
        if (rst) begin
            checkOutput({tag, ".rst_src"}, out_src, 0);
            checkOutput({tag, ".rst_msg"}, out_msg, 0);
            checkOutput({tag, ".rst_last"}, out_last, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // expected outputs from the arbitration rules using plain index arithmetic
    task automatic modelEval();
        eG = '0; eR = '0; eV = 1'b0; eSrc = '0; eLast = 1'b0; eMsg = '0;
        win = -1;
        if (!rstR) begin
            if (mBusy) begin
                win = mOwner;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && valR[(mPrio + k) % 4]) win = (mPrio + k) % 4;
                end
            end
            if (win >= 0) begin
                eG    = 4'b0001 << win;
                eSrc  = win[1:0];
                eV    = mBusy ? valR[win] : 1'b1;
                eR    = rdyR ? eG : 4'b0000;
                eLast = lastR[win];
                eMsg  = msgR[win*8 +: 8];
            end
        end
    endtask

    task automatic modelUpdate();
        if (rstR) begin
            mBusy = 0; mOwner = 0; mPrio = 0;
        end else if (win >= 0 && eV) begin
            if (rdyR && eLast) begin
                mBusy = 0;
                mPrio = (win + 1) % 4;
            end else begin
                mBusy  = 1;
                mOwner = win;
            end
        end
    endtask

    // track burst ownership and round-robin fairness from what the DUT actually did
    task automatic checkProtocol(input int c);
        if (rstR) begin
            burstOwner = -1;
            for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        end else begin
            if (burstOwner >= 0)
                checkOutput($sformatf("rnd%0d.burst_owner", c), grants, 4'b0001 << burstOwner);
            for (int i = 0; i < 4; i++) begin
                if (!in_val[i] || (grants[i] && out_val)) begin
                    waitCnt[i] = 0;
                end else if (out_val && out_rdy && out_last && !grants[i]) begin
                    waitCnt[i]++;
                    checkOutput($sformatf("rnd%0d.fair%0d", c, i), waitCnt[i] <= 3, 1);
                end
            end
            if (out_val && out_rdy) burstOwner = out_last ? -1 : int'(out_src);
        end
    endtask

    initial begin
        in_msg = 32'hA3A2A1A0;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);

        // reset, one full rotation of single-beat bursts, then a 3-beat burst from req0
        vecs[0] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[2] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3};
        vecs[5] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[6] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[7] = '{1'b0, 4'b0011, 4'b0011, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[8] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1};

        for (int i = 0; i < 9; i++) begin
            runCheck($sformatf("vec%0d", i), vecs[i].rst, vecs[i].val, vecs[i].last, vecs[i].rdy,
                     vecs[i].expGrants, vecs[i].expInRdy, vecs[i].expOutVal, vecs[i].expSrc);
        end

        // req2 stalled twice: source stays locked even when req3 joins
        runCheck("t3.stall0", 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2);
        runCheck("t3.stall1", 1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2);
        runCheck("t3.accept", 1'b0, 4'b1100, 4'b1100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2);
        runCheck("t3.next",   1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3);

        // owner req1 bubbles for two cycles while req0 waits
        runCheck("t4.pre",   1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0);
        runCheck("t4.beat1", 1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1);
        runCheck("t4.bub0",  1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd1);
        runCheck("t4.bub1",  1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd1);
        runCheck("t4.last",  1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1);
        runCheck("t4.req0",  1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0);

        // reset in the middle of req3's burst abandons it
        runCheck("t5.beat1", 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3);
        runCheck("t5.beat2", 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3);
        runCheck("t5.reset", 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        runCheck("t5.after", 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0);

        // randomized traffic: requesters mostly hold valid until their beat is taken
        valR = '0; accPrev = '0; burstOwner = -1;
        mBusy = 0; mOwner = 0; mPrio = 0;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            rstR = (c == 0) || ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 4; i++) begin
                if (valR[i] && !accPrev[i]) valR[i] = ($urandom_range(0, 15) != 0);
                else valR[i] = $urandom_range(0, 1) != 0;
                lastR[i] = ($urandom_range(0, 2) == 0);
            end
            rdyR = ($urandom_range(0, 3) != 0);
            msgR = $urandom;
            in_msg = msgR;
            applyStimulus(rstR, valR, lastR, rdyR);
            @(negedge clk);
            modelEval();
            checkOutput($sformatf("rnd%0d.grants", c), grants, eG);
            checkOutput($sformatf("rnd%0d.in_rdy", c), in_rdy, eR);
            checkOutput($sformatf("rnd%0d.out_val", c), out_val, eV);
            if (eV) begin
                checkOutput($sformatf("rnd%0d.out_src", c), out_src, eSrc);
                checkOutput($sformatf("rnd%0d.out_msg", c), out_msg, eMsg);
                checkOutput($sformatf("rnd%0d.out_last", c), out_last, eLast);
            end
            checkOutput($sformatf("rnd%0d.inv_rdy", c), $countones(in_rdy) <= 1, 1);
            checkOutput($sformatf("rnd%0d.inv_gnt", c), $countones(grants) <= 1, 1);
            checkOutput($sformatf("rnd%0d.inv_sub", c), in_rdy & ~grants, 0);
            checkProtocol(c);
            modelUpdate();
            accPrev = in_rdy & in_val;
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
